// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and bridge types for the core-side AXI master bridge.
package axi_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_STRB_W = AXI_DATA_W / 8;

   // AxSIZE code for a 4-byte beat (one bus word).
   localparam logic [2:0] SIZE_4B = 3'd2;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AWW,
      ST_B
   } bridge_state_e;

   // Request as captured at acceptance; the read/write choice is carried by the state.
   typedef struct packed {
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [AXI_DATA_W-1:0] wdata;
      logic [AXI_STRB_W-1:0] wstrb;
   } bridge_req_t;

   // Anything other than OKAY is reported to the core as an error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_master_bridge_if.sv
// Core request/response channel plus the io_master AXI4 bus, viewed from the bridge (master)
// and from the environment that serves it (slave).
interface axi_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [7:0]            req_len;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_wstrb;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_W-1:0]     resp_data;
   logic                  resp_last;
   logic                  resp_err;

   logic                  io_master_arvalid;
   logic                  io_master_arready;
   logic [ID_W-1:0]       io_master_arid;
   logic [ADDR_W-1:0]     io_master_araddr;
   logic [7:0]            io_master_arlen;
   logic [2:0]            io_master_arsize;
   logic [1:0]            io_master_arburst;

   logic                  io_master_rvalid;
   logic                  io_master_rready;
   logic [ID_W-1:0]       io_master_rid;
   logic [DATA_W-1:0]     io_master_rdata;
   logic [1:0]            io_master_rresp;
   logic                  io_master_rlast;

   logic                  io_master_awvalid;
   logic                  io_master_awready;
   logic [ID_W-1:0]       io_master_awid;
   logic [ADDR_W-1:0]     io_master_awaddr;
   logic [7:0]            io_master_awlen;
   logic [2:0]            io_master_awsize;
   logic [1:0]            io_master_awburst;

   logic                  io_master_wvalid;
   logic                  io_master_wready;
   logic [DATA_W-1:0]     io_master_wdata;
   logic [DATA_W/8-1:0]   io_master_wstrb;
   logic                  io_master_wlast;

   logic                  io_master_bvalid;
   logic                  io_master_bready;
   logic [ID_W-1:0]       io_master_bid;
   logic [1:0]            io_master_bresp;

   modport master (
      input  req_valid, req_we, req_addr, req_len, req_wdata, req_wstrb,
      output req_ready,
      output resp_valid, resp_data, resp_last, resp_err,
      input  resp_ready,
      output io_master_arvalid, io_master_arid, io_master_araddr, io_master_arlen,
             io_master_arsize, io_master_arburst,
      input  io_master_arready,
      input  io_master_rvalid, io_master_rid, io_master_rdata, io_master_rresp, io_master_rlast,
      output io_master_rready,
      output io_master_awvalid, io_master_awid, io_master_awaddr, io_master_awlen,
             io_master_awsize, io_master_awburst,
      input  io_master_awready,
      output io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
      input  io_master_wready,
      input  io_master_bvalid, io_master_bid, io_master_bresp,
      output io_master_bready
   );

   modport slave (
      output req_valid, req_we, req_addr, req_len, req_wdata, req_wstrb,
      input  req_ready,
      input  resp_valid, resp_data, resp_last, resp_err,
      output resp_ready,
      input  io_master_arvalid, io_master_arid, io_master_araddr, io_master_arlen,
             io_master_arsize, io_master_arburst,
      output io_master_arready,
      output io_master_rvalid, io_master_rid, io_master_rdata, io_master_rresp, io_master_rlast,
      input  io_master_rready,
      input  io_master_awvalid, io_master_awid, io_master_awaddr, io_master_awlen,
             io_master_awsize, io_master_awburst,
      output io_master_awready,
      input  io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
      output io_master_wready,
      output io_master_bvalid, io_master_bid, io_master_bresp,
      input  io_master_bready
   );

endinterface

// File: rtl/axi_write_tracker.sv
// Tracks the independent AW and W handshakes of a single-beat write: raises both valids on
// start, drops each one after its own handshake, and reports completion in the same cycle
// the second handshake lands.
module axi_write_tracker (
   input  logic clock,
   input  logic reset,
   input  logic i_start,
   input  logic i_awready,
   input  logic i_wready,
   output logic o_awvalid,
   output logic o_wvalid,
   output logic o_done
);

   logic r_awvalid;
   logic r_wvalid;
   logic r_aw_done;
   logic r_w_done;
   logic w_aw_hs;
   logic w_w_hs;

   assign w_aw_hs   = r_awvalid && i_awready;
   assign w_w_hs    = r_wvalid && i_wready;
   assign o_done    = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
   assign o_awvalid = r_awvalid;
   assign o_wvalid  = r_wvalid;

   // Valid/done bookkeeping; flags clear once both sides are through so the next write starts clean.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (i_start) begin
         r_awvalid <= 1'b1;
         r_wvalid  <= 1'b1;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (o_done) begin
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
         end
         if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4 master: turns core requests (IFU line fills, LSU accesses) into
// INCR read bursts or single-beat writes on io_master_*, and streams beats/completions back.
module axi_master_bridge
   import axi_pkg::*;
#(
   parameter int              ADDR_W = AXI_ADDR_W,
   parameter int              DATA_W = AXI_DATA_W,
   parameter int              ID_W   = 4,
   parameter logic [ID_W-1:0] ID_VAL = '0
) (
   input  logic                clock,
   input  logic                reset,
   axi_master_bridge_if.master bus
);

   localparam int STRB_W = DATA_W / 8;

   bridge_state_e r_state;
   bridge_req_t   r_req;
   logic [7:0]    r_cnt;
   logic          r_arvalid;

   logic w_accept;
   logic w_start_wr;
   logic w_rbeat;
   logic w_rfinal;
   logic w_bbeat;
   logic w_wr_done;
   logic w_awvalid;
   logic w_wvalid;
   logic w_in_ar;
   logic w_in_aww;

   assign w_accept   = (r_state == ST_IDLE) && bus.req_valid;
   assign w_start_wr = w_accept && bus.req_we;
   assign w_rbeat    = (r_state == ST_R) && bus.io_master_rvalid && bus.resp_ready;
   assign w_rfinal   = bus.io_master_rlast || (r_cnt == r_req.len);
   assign w_bbeat    = (r_state == ST_B) && bus.io_master_bvalid && bus.resp_ready;
   assign w_in_ar    = (r_state == ST_AR);
   assign w_in_aww   = (r_state == ST_AWW);

   axi_write_tracker u_write_tracker (
      .clock     (clock),
      .reset     (reset),
      .i_start   (w_start_wr),
      .i_awready (bus.io_master_awready),
      .i_wready  (bus.io_master_wready),
      .o_awvalid (w_awvalid),
      .o_wvalid  (w_wvalid),
      .o_done    (w_wr_done)
   );

   // Transaction sequencer: accepts a request, runs AR+R or AW/W+B, returns to IDLE.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_req     <= '0;
         r_cnt     <= 8'd0;
         r_arvalid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_req.addr  <= AXI_ADDR_W'(bus.req_addr);
                  r_req.len   <= bus.req_len;
                  r_req.wdata <= AXI_DATA_W'(bus.req_wdata);
                  r_req.wstrb <= AXI_STRB_W'(bus.req_wstrb);
                  if (bus.req_we) begin
                     r_state <= ST_AWW;
                  end else begin
                     r_state   <= ST_AR;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            ST_AR: begin
               if (bus.io_master_arready) begin
                  r_arvalid <= 1'b0;
                  r_cnt     <= 8'd0;
                  r_state   <= ST_R;
               end
            end
            ST_R: begin
               if (w_rbeat) begin
                  r_cnt <= r_cnt + 8'd1;
                  if (w_rfinal) r_state <= ST_IDLE;
               end
            end
            ST_AWW: begin
               if (w_wr_done) r_state <= ST_B;
            end
            ST_B: begin
               if (w_bbeat) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready = (r_state == ST_IDLE);

   assign bus.io_master_arvalid = r_arvalid;
   assign bus.io_master_arid    = ID_VAL;
   assign bus.io_master_araddr  = ADDR_W'(r_req.addr);
   assign bus.io_master_arlen   = r_req.len;
   assign bus.io_master_arsize  = w_in_ar ? SIZE_4B : 3'd0;
   assign bus.io_master_arburst = w_in_ar ? BURST_INCR : BURST_FIXED;

   assign bus.io_master_awvalid = w_awvalid;
   assign bus.io_master_awid    = ID_VAL;
   assign bus.io_master_awaddr  = ADDR_W'(r_req.addr);
   assign bus.io_master_awlen   = 8'd0;
   assign bus.io_master_awsize  = w_in_aww ? SIZE_4B : 3'd0;
   assign bus.io_master_awburst = w_in_aww ? BURST_INCR : BURST_FIXED;

   assign bus.io_master_wvalid  = w_wvalid;
   assign bus.io_master_wdata   = DATA_W'(r_req.wdata);
   assign bus.io_master_wstrb   = STRB_W'(r_req.wstrb);
   assign bus.io_master_wlast   = w_in_aww;

   // Response steering: R beats and B completions pass straight through to the core, with
   // the core's ready doubling as rready/bready so backpressure reaches the responder.
   always_comb begin
      bus.resp_valid       = 1'b0;
      bus.resp_data        = '0;
      bus.resp_last        = 1'b0;
      bus.resp_err         = 1'b0;
      bus.io_master_rready = 1'b0;
      bus.io_master_bready = 1'b0;
      case (r_state)
         ST_R: begin
            bus.io_master_rready = bus.resp_ready;
            bus.resp_valid       = bus.io_master_rvalid;
            bus.resp_data        = bus.io_master_rdata;
            bus.resp_last        = bus.io_master_rlast;
            bus.resp_err         = resp_is_err(bus.io_master_rresp) ||
                                   (bus.io_master_rlast != (r_cnt == r_req.len));
         end
         ST_B: begin
            bus.io_master_bready = bus.resp_ready;
            bus.resp_valid       = bus.io_master_bvalid;
            bus.resp_last        = 1'b1;
            bus.resp_err         = resp_is_err(bus.io_master_bresp);
         end
         default: begin
         end
      endcase
   end

endmodule
